// File: rtl/function_scan_ctrl.sv
// function_scan_ctrl: exhaustive truth-table scan of a decoder-based
// 4-input function unit. Each minterm is driven for SETTLE+1 cycles,
// f is sampled on the last cycle, and the captured table is compared
// against a golden table when the scan completes.
// The captured-table port is named scan_table because "table" is a
// reserved word in SystemVerilog.
module function_scan_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] expected,
    input  logic        f,
    output logic [3:0]  abcd,
    output logic        en,
    output logic        busy,
    output logic        done,
    output logic [15:0] scan_table,
    output logic        match,
    output logic [3:0]  first_fail
);

    localparam logic [3:0] SETTLE_C = SETTLE[3:0];

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        FINISH
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  idx;
    logic [3:0]  cnt;
    logic        capture;
    logic        last;
    logic [15:0] table_nxt;
    logic [15:0] diff;
    logic        match_nxt;
    logic [3:0]  ff_nxt;
    logic        found;

    // Capture happens on the last settle cycle unless an abort overrides it
    always_comb begin
        capture = (state == DRIVE) && !abort && (cnt == SETTLE_C);
        last    = capture && (idx == 4'd15);
    end

    // Comparison result including the bit being captured on this edge
    always_comb begin
        table_nxt      = scan_table;
        table_nxt[idx] = f;
        diff           = table_nxt ^ expected;
        match_nxt      = (diff == '0);
        ff_nxt         = '0;
        found          = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (diff[i] && !found) begin
                ff_nxt = 4'(i);
                found  = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = DRIVE;
            DRIVE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (last) begin
                    state_nxt = FINISH;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from state
    always_comb begin
        abcd = '0;
        en   = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            DRIVE: begin
                abcd = idx;
                en   = 1'b1;
                busy = 1'b1;
            end
            FINISH:  done = 1'b1;
            default: ;
        endcase
    end

    // Minterm index, settle counter and table capture
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            idx        <= '0;
            cnt        <= '0;
            scan_table <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                idx        <= '0;
                cnt        <= '0;
                scan_table <= '0;
            end
        end else if (state == DRIVE && !abort) begin
            if (capture) begin
                scan_table[idx] <= f;
                cnt             <= '0;
                if (idx != 4'd15) begin
                    idx <= idx + 4'd1;
                end
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    // Result registers, updated only on a completed scan
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            match      <= 1'b0;
            first_fail <= '0;
        end else if (last) begin
            match      <= match_nxt;
            first_fail <= ff_nxt;
        end
    end

endmodule

// File: tb/tb_function_scan_ctrl.sv
// Bench for function_scan_ctrl: two instances (SETTLE=0 and SETTLE=1)
// share stimulus; a position-based scan model predicts every output.
module tb_function_scan_ctrl;

    logic        clk  = 1'b0;
    logic        nrst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] expected = '0;
    logic [15:0] tt [2];
    logic [1:0]  glitch = '0;
    logic [1:0]  f;
    logic [1:0]  en, busy, done, match;
    logic [3:0]  abcd [2];
    logic [15:0] tbl [2];
    logic [3:0]  ffo [2];

    int n_tests = 0;
    int n_fail  = 0;

    // model: per-DUT cycles per minterm, scan position, results
    int          per [2] = '{1, 2};
    bit          m_scan [2];
    bit          m_fin [2];
    int          m_pos [2];
    logic [15:0] m_tbl [2];
    logic        m_match [2];
    logic [3:0]  m_ff [2];

    always #5 clk = ~clk;

    // function unit under scan: truth table lookup, with noise on
    // cycles where the controller is not supposed to sample
    assign f[0] = en[0] ? (tt[0][abcd[0]] ^ glitch[0]) : 1'b0;
    assign f[1] = en[1] ? (tt[1][abcd[1]] ^ glitch[1]) : 1'b0;

    function_scan_ctrl #(.SETTLE(0)) u0 (
        .clk(clk), .nrst(nrst), .start(start), .abort(abort),
        .expected(expected), .f(f[0]), .abcd(abcd[0]), .en(en[0]),
        .busy(busy[0]), .done(done[0]), .scan_table(tbl[0]),
        .match(match[0]), .first_fail(ffo[0]));

    function_scan_ctrl #(.SETTLE(1)) u1 (
        .clk(clk), .nrst(nrst), .start(start), .abort(abort),
        .expected(expected), .f(f[1]), .abcd(abcd[1]), .en(en[1]),
        .busy(busy[1]), .done(done[1]), .scan_table(tbl[1]),
        .match(match[1]), .first_fail(ffo[1]));

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_scan[d] = 0; m_fin[d] = 0; m_pos[d] = 0;
            m_tbl[d] = '0; m_match[d] = 1'b0; m_ff[d] = '0;
        end
    endtask

    task automatic model_edge();
        logic [15:0] diff;
        if (!nrst) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            if (m_fin[d]) begin
                m_fin[d] = 0;
            end else if (!m_scan[d]) begin
                if (start) begin
                    m_scan[d] = 1; m_pos[d] = 0; m_tbl[d] = '0;
                end
            end else if (abort) begin
                m_scan[d] = 0;
            end else begin
                if (m_pos[d] % per[d] == per[d] - 1)
                    m_tbl[d][m_pos[d] / per[d]] = tt[d][m_pos[d] / per[d]];
                m_pos[d]++;
                if (m_pos[d] == 16 * per[d]) begin
                    m_scan[d]  = 0;
                    m_fin[d]   = 1;
                    diff       = m_tbl[d] ^ expected;
                    m_match[d] = (diff == '0);
                    m_ff[d]    = '0;
                    for (int i = 15; i >= 0; i--)
                        if (diff[i]) m_ff[d] = 4'(i);
                end
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("busy%0d", d), 16'(busy[d]), 16'(m_scan[d]));
            chk($sformatf("en%0d", d), 16'(en[d]), 16'(m_scan[d]));
            chk($sformatf("abcd%0d", d), 16'(abcd[d]),
                m_scan[d] ? 16'(m_pos[d] / per[d]) : 16'h0);
            chk($sformatf("done%0d", d), 16'(done[d]), 16'(m_fin[d]));
            chk($sformatf("table%0d", d), tbl[d], m_tbl[d]);
            chk($sformatf("match%0d", d), 16'(match[d]), 16'(m_match[d]));
            chk($sformatf("first_fail%0d", d), 16'(ffo[d]), 16'(m_ff[d]));
        end
    endtask

    // one clock: model follows the edge, outputs compared at the negedge
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            glitch[d] = (m_scan[d] && (m_pos[d] % per[d]) != per[d] - 1) ? 1'($urandom) : 1'b0;
        check_all();
    endtask

    // start pulse at cycle 0, observe ncyc cycles, report done cycles
    task automatic scan_pulse(input int ncyc, output int dc1, output int dc0);
        dc1 = -1; dc0 = -1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            if (done[1] && dc1 < 0) dc1 = c;
            if (done[0] && dc0 < 0) dc0 = c;
            if (c <= 16) chk("abcd0_step", 16'(abcd[0]), 16'(c - 1));
            if (c <= 32) chk("busy1_window", 16'(busy[1]), 16'h1);
            step();
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 60 && (busy != 2'b00 || done != 2'b00); c++) step();
        chk("drain_idle", 16'({busy, done}), 16'h0);
    endtask

    initial begin
        int dc1, dc0, ndone, k;
        int dcyc [3];
        tt[0] = 16'h28AC; tt[1] = 16'h28AC;
        model_reset();

        // reset state
        @(negedge clk);
        check_all();
        chk("rst_table", tbl[1], 16'h0000);
        nrst = 1'b1;
        step(); step();
        chk("idle_wait", 16'(busy[1]), 16'h0);

        // full scan, matching golden table
        expected = 16'h28AC;
        scan_pulse(40, dc1, dc0);
        chk("done1_cycle", 16'(dc1), 16'd33);
        chk("done0_cycle", 16'(dc0), 16'd17);
        chk("table_28AC", tbl[1], 16'h28AC);
        chk("match_1", 16'(match[1]), 16'h1);
        chk("ff_0", 16'(ffo[1]), 16'h0);

        // mismatch at minterm 0, then at minterm 15
        expected = 16'h28AD;
        scan_pulse(40, dc1, dc0);
        chk("done1_cycle_b", 16'(dc1), 16'd33);
        chk("match_0", 16'(match[1]), 16'h0);
        chk("ff_0_mis", 16'(ffo[1]), 16'h0);
        expected = 16'hA8AC;
        scan_pulse(40, dc1, dc0);
        chk("ff_15", 16'(ffo[1]), 16'd15);
        chk("match_0_b", 16'(match[1]), 16'h0);

        // start held high: done every 34 cycles
        start = 1'b1;
        k = 0;
        for (int c = 1; c <= 110; c++) begin
            step();
            if (done[1] && k < 3) begin dcyc[k] = c; k++; end
        end
        start = 1'b0;
        chk("held_ndone", 16'(k), 16'd3);
        chk("held_period_a", 16'(dcyc[1] - dcyc[0]), 16'd34);
        chk("held_period_b", 16'(dcyc[2] - dcyc[1]), 16'd34);
        drain();

        // stray start pulses mid-scan
        start = 1'b1;
        step();
        ndone = 0; dc1 = -1;
        for (int c = 1; c <= 70; c++) begin
            start = (c == 5 || c == 20 || c == 31) ? 1'b1 : 1'b0;
            if (done[1]) begin ndone++; dc1 = c; end
            step();
        end
        start = 1'b0;
        chk("stray_ndone", 16'(ndone), 16'd1);
        chk("stray_cycle", 16'(dc1), 16'd33);
        drain();

        // abort while abcd=7, first settle cycle
        expected = 16'h28AC;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 15; c++) step();
        chk("abort_abcd7", 16'(abcd[1]), 16'd7);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", 16'(busy[1]), 16'h0);
        chk("abort_en", 16'(en[1]), 16'h0);
        chk("abort_table", tbl[1], 16'h002C);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done[1]) ndone++;
            step();
        end
        chk("abort_nodone", 16'(ndone), 16'd0);
        chk("abort_keep_ff", 16'(ffo[1]), 16'd15);
        drain();

        // asynchronous reset in the middle of a scan
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 10; c++) step();
        #2 nrst = 1'b0;
        #1;
        chk("arst_busy", 16'(busy[1]), 16'h0);
        chk("arst_en", 16'(en[1]), 16'h0);
        chk("arst_abcd", 16'(abcd[1]), 16'h0);
        chk("arst_done", 16'(done[1]), 16'h0);
        chk("arst_table", tbl[1], 16'h0);
        chk("arst_match", 16'(match[1]), 16'h0);
        chk("arst_ff", 16'(ffo[1]), 16'h0);
        model_reset();
        step();
        nrst = 1'b1;
        step();
        scan_pulse(40, dc1, dc0);
        chk("post_rst_done", 16'(dc1), 16'd33);
        chk("post_rst_match", 16'(match[1]), 16'h1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom % 4 == 0);
            abort = ($urandom % 40 == 0);
            if ($urandom % 50 == 0) begin
                tt[1] = 16'($urandom);
                tt[0] = tt[1];
            end
            if ($urandom % 20 == 0)
                expected = tt[1] ^ (($urandom % 2 == 0) ? 16'h0 : (16'h1 << ($urandom % 16)));
            step();
        end
        start = 1'b0;
        abort = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/function_scan_ctrl.md
FUNCTION_SCAN_CTRL -- requirements
Module: function_scan_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; it SHALL have no other clock or reset.
REQ-002 The block SHALL have parameter SETTLE, default 1, giving settle cycles per minterm before sampling f (legal range 0..15).
REQ-003 The block SHALL have these ports, one per line:
- clk  in  1  rising-edge clock
- nrst  in  1  asynchronous active-low reset
- start  in  1  scan request, level-sampled in IDLE only
- abort  in  1  cancel scan in progress
- expected  in  16  golden truth table, bit i = f at minterm i
- f  in  1  output of the decoder-based function unit under scan
- abcd  out  4  minterm applied to the decoder select inputs (a = abcd[3])
- en  out  1  decoder enable
- busy  out  1  scan in progress
- done  out  1  one-cycle completion pulse
- table  out  16  captured truth table
- match  out  1  table equals expected, valid with and after done
- first_fail  out  4  lowest mismatching minterm index, valid when match=0

Function
REQ-004 The block SHALL implement states IDLE, DRIVE and FINISH, with a 4-bit minterm index idx and a 4-bit settle counter cnt.
REQ-005 In IDLE, start=1 at a clock edge SHALL move the block to DRIVE with idx=0, cnt=0 and table=16'h0000.
REQ-006 In IDLE, start=0 SHALL hold IDLE.
REQ-007 In IDLE, en=0, abcd=0 and busy=0.
REQ-008 In DRIVE, en=1, abcd=idx and busy=1.
REQ-009 In DRIVE, cnt SHALL increment each cycle until cnt==SETTLE.
REQ-010 In DRIVE, on the cycle cnt==SETTLE, f SHALL be captured into table[idx] at the clock edge and cnt SHALL clear.
REQ-011 On the capture edge, idx SHALL increment if idx<15; if idx==15, the state SHALL go to FINISH.
REQ-012 Each minterm SHALL occupy exactly SETTLE+1 cycles; a full scan SHALL occupy 16*(SETTLE+1) DRIVE cycles.
REQ-013 In FINISH, done=1 for exactly one cycle, busy=0 and en=0, and the next state SHALL be IDLE.
REQ-014 match and first_fail SHALL be registered on entry to FINISH and held until the next scan completes.
REQ-015 match SHALL be (table==expected), where table includes the final capture.
REQ-016 first_fail SHALL be the lowest i with table[i]!=expected[i], or 0 when match=1.
REQ-017 expected SHALL be sampled only on entry to FINISH.
REQ-018 start while busy=1 SHALL be ignored.
REQ-019 start held high SHALL produce back-to-back scans, each preceded by one IDLE cycle.
REQ-020 abort=1 in DRIVE SHALL return the block to IDLE on the next edge, with no done pulse and no capture on that edge.
REQ-021 After an abort, table SHALL keep the bits already captured, and match and first_fail SHALL keep their previous values.
REQ-022 If abort and a capture occur on the same edge, abort SHALL win.
REQ-023 abort in IDLE or FINISH SHALL have no effect; FINISH always completes.
REQ-024 Wrap-around: idx SHALL never wrap within a scan; index 15 is terminal.

Reset
REQ-025 nrst=0 SHALL immediately (asynchronously) force the state to IDLE and set abcd=0, en=0, busy=0, done=0, table=0, match=0, first_fail=0, idx=0 and cnt=0.
REQ-026 Reset asserted mid-scan SHALL discard the scan with no done pulse.
REQ-027 After reset release, the block SHALL wait for start.

Verification
REQ-028 The bench SHALL cover these directed scenarios (f model: truth table 16'h28AC, i.e. f=1 at minterms 2,3,5,7,11,13):
- SETTLE=1, expected=16'h28AC, start pulse at cycle 0 -> busy=1 in cycles 1..32, done=1 in cycle 33, table=16'h28AC, match=1, first_fail=0.
- SETTLE=1, expected=16'h28AD -> done in cycle 33, match=0, first_fail=0; expected=16'hA8AC -> first_fail=15.
- SETTLE=0, start pulse -> one cycle per minterm, abcd steps 0..15 in cycles 1..16, done in cycle 17.
- start held high, SETTLE=1 -> done pulses every 34 cycles; start pulses injected mid-scan -> no extra scans, no timing change.
- abort=1 while abcd=7 and cnt=0 -> busy=0 next cycle, no done, en=0, table=16'h002C.
- nrst=0 at cycle 10 of a scan -> all outputs 0 without waiting for a clock edge; after release, start -> a clean full scan with done at 33 cycles after start.
